// File: rtl/alu_defs_pkg.sv
// Shared ALU definitions: op encodings, execute-stage FSM states and NZCV flag bit positions.
package alu_defs;

    localparam logic [2:0] AND_      = 3'b000;
    localparam logic [2:0] OR_       = 3'b001;
    localparam logic [2:0] MOV_      = 3'b010;
    localparam logic [2:0] ARITH_ADD = 3'b011;
    localparam logic [2:0] ARITH_SUB = 3'b100;
    localparam logic [2:0] ARITH_MUL = 3'b101;

    typedef enum logic [1:0] {EX_IDLE, EX_MUL, EX_DONE} ex_state_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier: one partial product per cycle, early exit once the multiplier is exhausted.
module seq_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mult_q, mult_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    count_q, count_d;
    logic             run_q, run_d;

    // done is combinational so the stage leaves MUL on the same edge the last iteration lands.
    assign done    = run_q & ((mult_q == '0) | (count_q == '0));
    assign product = acc_q;

    always_comb begin
        // NOTE: every output gets a default first, so no path through the branches infers a latch.
        mcand_d = mcand_q;
        mult_d  = mult_q;
        acc_d   = acc_q;
        count_d = count_q;
        run_d   = run_q;
        if (start) begin
            mcand_d = a;
            mult_d  = b;
            acc_d   = '0;
            count_d = CW'(WIDTH);
            run_d   = 1'b1;
        end else if (done) begin
            run_d = 1'b0;
        end else if (run_q) begin
            if (mult_q[0]) acc_d = acc_q + mcand_q;
            mcand_d = mcand_q << 1;
            mult_d  = mult_q >> 1;
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            mcand_q <= '0;
            mult_q  <= '0;
            acc_q   <= '0;
            count_q <= '0;
            run_q   <= 1'b0;
        end else begin
            mcand_q <= mcand_d;
            mult_q  <= mult_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            run_q   <= run_d;
        end
    end

endmodule

// File: rtl/alu_exec_stage.sv
// Execute stage: single-cycle logic/add/sub ops, iterative MUL, valid/ready on both sides, registered NZCV.
module alu_exec_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       alu_ctrl,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic             busy
);

    import alu_defs::*;

    localparam int MSB = WIDTH - 1;

    ex_state_t        state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [3:0]       flags_q, flags_d;
    logic             out_valid_q, out_valid_d;

    logic             fire_in, fire_out, mul_start, mul_done;
    logic [WIDTH-1:0] mul_product;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c, alu_v;

    function automatic logic [3:0] pack_flags(logic [WIDTH-1:0] res, logic c, logic v);
        logic [3:0] f;
        f[FLAG_N] = res[MSB];
        f[FLAG_Z] = (res == '0);
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        return f;
    endfunction

    assign in_ready  = ~reset & (state_q == EX_IDLE) & (~out_valid_q | out_ready);
    assign fire_in   = in_valid & in_ready;
    assign fire_out  = out_valid_q & out_ready;
    assign mul_start = fire_in & (alu_ctrl == ARITH_MUL);

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign flags     = flags_q;
    assign busy      = (state_q == EX_MUL);

    seq_multiplier #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .a       (src_a),
        .b       (src_b),
        .done    (mul_done),
        .product (mul_product)
    );

    // Unknown op codes fall to the default: result 0, so Z alone is set.
    always_comb begin
        sum     = '0;
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (alu_ctrl)
            AND_: alu_res = src_a & src_b;
            OR_:  alu_res = src_a | src_b;
            MOV_: alu_res = src_b;
            ARITH_ADD: begin
                sum     = {1'b0, src_a} + {1'b0, src_b};
                alu_res = sum[MSB:0];
                alu_c   = sum[WIDTH];
                alu_v   = (src_a[MSB] == src_b[MSB]) & (alu_res[MSB] != src_a[MSB]);
            end
            ARITH_SUB: begin
                sum     = {1'b0, src_a} - {1'b0, src_b};
                alu_res = sum[MSB:0];
                alu_c   = ~sum[WIDTH];
                alu_v   = (src_a[MSB] != src_b[MSB]) & (alu_res[MSB] != src_a[MSB]);
            end
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        flags_d     = flags_q;
        out_valid_d = out_valid_q;
        case (state_q)
            EX_IDLE: begin
                if (mul_start) begin
                    state_d     = EX_MUL;
                    out_valid_d = 1'b0;
                end else if (fire_in) begin
                    result_d    = alu_res;
                    flags_d     = pack_flags(alu_res, alu_c, alu_v);
                    out_valid_d = 1'b1;
                end else if (fire_out) begin
                    out_valid_d = 1'b0;
                end
            end
            EX_MUL: begin
                if (mul_done) begin
                    state_d     = EX_DONE;
                    result_d    = mul_product;
                    flags_d     = pack_flags(mul_product, 1'b0, 1'b0);
                    out_valid_d = 1'b1;
                end
            end
            EX_DONE: begin
                if (fire_out) begin
                    state_d     = EX_IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = EX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= EX_IDLE;
            result_q    <= '0;
            flags_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Scoreboard bench for alu_exec_stage: expected results queued on accept, compared on each output beat.
module tb_alu_exec_stage;

    import alu_defs::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [2:0]   alu_ctrl = 3'b000;
    logic [W-1:0] src_a = '0;
    logic [W-1:0] src_b = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] result;
    logic [3:0]   flags;
    logic         busy;

    alu_exec_stage #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_ctrl  (alu_ctrl),
        .src_a     (src_a),
        .src_b     (src_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [35:0] exp_q[$];
    logic        last_fire_in = 1'b0;
    logic        stall_prev = 1'b0;
    logic [35:0] held = '0;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: {result, N, Z, C, V}; overflow from signed 64-bit arithmetic.
    function automatic logic [35:0] model(logic [2:0] op, logic [31:0] a, logic [31:0] b);
        logic [31:0] r;
        logic        c;
        logic        v;
        longint      sa;
        longint      sbv;
        longint      s;
        r = '0;
        c = 1'b0;
        v = 1'b0;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        case (op)
            AND_: r = a & b;
            OR_:  r = a | b;
            MOV_: r = b;
            ARITH_ADD: begin
                r = a + b;
                c = (r < a);
                s = sa + sbv;
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            ARITH_SUB: begin
                r = a - b;
                c = (a >= b);
                s = sa - sbv;
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            ARITH_MUL: r = a * b;
            default:   r = '0;
        endcase
        return {r, r[31], (r == 32'd0), c, v};
    endfunction

    // Sample at negedge+1 with the inputs that the coming posedge will see, then advance.
    task automatic tick();
        logic [35:0] e;
        #1;
        last_fire_in = in_valid & in_ready;
        if (stall_prev) begin
            check("hold_valid", out_valid, 1);
            check("hold_data", {result, flags}, held);
        end
        if (out_valid & ~out_ready) check("stall_in_ready", in_ready, 0);
        if (out_valid & out_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_beat", out_valid, 0);
            end else begin
                e = exp_q.pop_front();
                check("sb_result", result, e[35:4]);
                check("sb_flags", flags, e[3:0]);
            end
        end
        if (last_fire_in) exp_q.push_back(model(alu_ctrl, src_a, src_b));
        stall_prev = out_valid & ~out_ready;
        held       = {result, flags};
        @(negedge clk);
    endtask

    task automatic send(logic [2:0] op, logic [W-1:0] a, logic [W-1:0] b);
        int n;
        n = 0;
        in_valid = 1'b1;
        alu_ctrl = op;
        src_a    = a;
        src_b    = b;
        do begin
            tick();
            n++;
        end while (!last_fire_in && n < 100);
        if (!last_fire_in) check("accept_timeout", last_fire_in, 1);
        in_valid = 1'b0;
    endtask

    // k counts edges from the accept edge: k=1 means valid right after accepting.
    task automatic wait_valid(output int k, input logic expect_busy);
        k = 1;
        while (!out_valid && k < 60) begin
            if (expect_busy) begin
                check("mul_busy", busy, 1);
                check("mul_in_ready", in_ready, 0);
            end
            tick();
            k++;
        end
        if (!out_valid) check("valid_timeout", out_valid, 1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        in_valid = 1'b0;
        while (exp_q.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          k;
        int          idx;
        int          early_acc;
        logic [2:0]  ops[6];
        logic [31:0] da[6];
        logic [31:0] db[6];

        repeat (2) @(negedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_flags", flags, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("idle_in_ready", in_ready, 1);

        // ADD overflow into the sign bit
        send(ARITH_ADD, 32'h7FFF_FFFF, 32'h1);
        wait_valid(k, 1'b0);
        check("add_latency", k, 1);
        check("add_result", result, 32'h8000_0000);
        check("add_flags", flags, 4'b1001);
        drain();

        send(ARITH_SUB, 32'd5, 32'd5);
        wait_valid(k, 1'b0);
        check("sub_eq_result", result, 32'h0);
        check("sub_eq_flags", flags, 4'b0110);
        drain();
        send(ARITH_SUB, 32'd3, 32'd5);
        wait_valid(k, 1'b0);
        check("sub_lt_result", result, 32'hFFFF_FFFE);
        check("sub_lt_flags", flags, 4'b1000);
        drain();

        // MUL with a pending op held on the input; it must not be taken until after the MUL beat
        send(ARITH_MUL, 32'h1234, 32'h10);
        in_valid = 1'b1;
        alu_ctrl = OR_;
        src_a    = 32'h0F0F_0000;
        src_b    = 32'h0000_00F0;
        wait_valid(k, 1'b1);
        check("mul_latency_bound", (k <= 33), 1);
        check("mul_result", result, 32'h12340);
        check("mul_flags", flags, 4'b0000);
        check("mul_done_busy", busy, 0);
        check("mul_done_in_ready", in_ready, 0);
        send(OR_, 32'h0F0F_0000, 32'h0000_00F0);
        drain();

        // Streaming logic ops with a 3-cycle downstream stall
        ops = '{AND_, OR_, MOV_, AND_, OR_, MOV_};
        for (int i = 0; i < 6; i++) begin
            da[i] = $urandom;
            db[i] = $urandom;
        end
        idx = 0;
        early_acc = 0;
        for (int cyc = 0; cyc < 40 && (idx < 6 || exp_q.size() != 0); cyc++) begin
            out_ready = !(cyc >= 2 && cyc < 5);
            if (idx < 6) begin
                in_valid = 1'b1;
                alu_ctrl = ops[idx];
                src_a    = da[idx];
                src_b    = db[idx];
            end else begin
                in_valid = 1'b0;
            end
            tick();
            if (last_fire_in) begin
                idx++;
                if (cyc < 2) early_acc++;
            end
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        check("stream_rate", early_acc, 2);
        check("stream_sent", idx, 6);
        check("stream_drained", exp_q.size(), 0);

        // Reset during MUL aborts it
        send(ARITH_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (9) tick();
        reset = 1'b1;
        #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_in_ready", in_ready, 0);
        exp_q.delete();
        stall_prev = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_idle", in_ready, 1);
        send(ARITH_ADD, 32'd2, 32'd2);
        wait_valid(k, 1'b0);
        check("post_abort_add", result, 32'd4);
        drain();

        // Unknown op and multiply by zero
        send(3'b111, 32'd123, 32'd456);
        wait_valid(k, 1'b0);
        check("unk_result", result, 32'h0);
        check("unk_flags", flags, 4'b0100);
        drain();
        send(ARITH_MUL, 32'hDEAD_BEEF, 32'h0);
        wait_valid(k, 1'b1);
        check("mul0_latency", k, 2);
        check("mul0_result", result, 32'h0);
        check("mul0_flags", flags, 4'b0100);
        drain();

        // Random mix with random backpressure
        for (int cyc = 0; cyc < 400; cyc++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (!in_valid || last_fire_in) begin
                in_valid = ($urandom_range(0, 1) == 1);
                alu_ctrl = 3'($urandom_range(0, 7));
                src_a    = $urandom;
                src_b    = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
            end
            tick();
        end
        out_ready = 1'b1;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
